shift_load_ctrl: RTL and testbench

SHIFT_LOAD_CTRL -- requirements
Module: shift_load_ctrl

---
 rtl/shift_load_ctrl.sv | 131 +++++++++++++
 tb/tb_shift_load_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shift_load_ctrl.sv
// Parallel-load / serial-shift controller: a WIDTH-stage mux-flop chain driven by an
// IDLE/SHIFT/DONE state machine that serializes one accepted word at a time.
module shift_load_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    output logic             L,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last,
    output logic             done,
    output logic             busy
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             ser_valid_reg;
    logic             last_reg;
    logic             done_reg;
    logic             busy_reg;
    logic             shift_en;

    // Reset masks the handshake so nothing is offered as accepted while it is held.
    assign in_ready = (state_reg == IDLE) && !reset;
    assign L        = in_ready && in_valid;
    assign shift_en = (state_reg == SHIFT) && !hold;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_stage
            logic nb;
            if (MSB_FIRST != 0) begin : g_up
                if (gi == 0) begin : g_fill
                    assign nb = 1'b0;
                end else begin : g_link
                    assign nb = shift_reg[gi-1];
                end
            end else begin : g_down
                if (gi == WIDTH - 1) begin : g_fill
                    assign nb = 1'b0;
                end else begin : g_link
                    assign nb = shift_reg[gi+1];
                end
            end
            assign shift_next[gi] = L ? in_data[gi] : (shift_en ? nb : shift_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ser_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg     <= SHIFT;
                        cnt_reg       <= '0;
                        ser_valid_reg <= 1'b1;
                        last_reg      <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!hold) begin
                        if (cnt_reg == CNT_MAX) begin
                            state_reg     <= DONE;
                            cnt_reg       <= '0;
                            ser_valid_reg <= 1'b0;
                            last_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            cnt_reg  <= cnt_reg + 1'b1;
                            // last is precomputed so it lines up with the final bit
                            last_reg <= ((cnt_reg + 1'b1) == CNT_MAX);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    cnt_reg       <= '0;
                    ser_valid_reg <= 1'b0;
                    last_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign ser_out   = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
    assign ser_valid = ser_valid_reg;
    assign last      = last_reg;
    assign done      = done_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Directed bench: an MSB-first and an LSB-first instance share all inputs and are checked
// bit by bit against hand-known words.
module tb_shift_load_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       hold;

    logic in_ready_a, l_a, ser_out_a, ser_valid_a, last_a, done_a, busy_a;
    logic in_ready_b, l_b, ser_out_b, ser_valid_b, last_b, done_b, busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_load_ctrl #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .hold(hold), .L(l_a), .ser_out(ser_out_a),
        .ser_valid(ser_valid_a), .last(last_a), .done(done_a), .busy(busy_a)
    );

    shift_load_ctrl #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .hold(hold), .L(l_b), .ser_out(ser_out_b),
        .ser_valid(ser_valid_b), .last(last_b), .done(done_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer w, then walk the serial stream; hold is raised for hold_len cycles while
    // bit hold_at is showing. keep_valid leaves in_valid high with junk_data during the word.
    task automatic run_word(input logic [7:0] w, input int hold_at, input int hold_len,
                            input logic offer_hold, input logic keep_valid,
                            input logic [7:0] junk_data);
        int k    = 0;
        int held = 0;
        chk("idle_ready_a", in_ready_a, 1);
        chk("idle_busy_a", busy_a, 0);
        in_valid = 1'b1;
        in_data  = w;
        hold     = offer_hold;
        #1;
        chk("load_L_a", l_a, 1);
        chk("load_L_b", l_b, 1);
        step();
        in_valid = keep_valid;
        in_data  = junk_data;
        hold     = 1'b0;
        #1;
        while (k < 8) begin
            chk("sv_a", ser_valid_a, 1);
            chk("sv_b", ser_valid_b, 1);
            chk("bit_msb", ser_out_a, w[7-k]);
            chk("bit_lsb", ser_out_b, w[k]);
            chk("last_a", last_a, (k == 7));
            chk("last_b", last_b, (k == 7));
            chk("busy_a", busy_a, 1);
            chk("rdy_shift_a", in_ready_a, 0);
            chk("L_shift_a", l_a, 0);
            if (k == hold_at && held < hold_len) begin
                hold = 1'b1;
                held++;
            end else begin
                hold = 1'b0;
                k++;
            end
            step();
        end
        chk("done_a", done_a, 1);
        chk("done_b", done_b, 1);
        chk("done_sv_a", ser_valid_a, 0);
        chk("done_last_a", last_a, 0);
        chk("done_busy_a", busy_a, 1);
        chk("done_rdy_a", in_ready_a, 0);
        chk("done_L_a", l_a, 0);
        hold = 1'b1;
        step();
        hold = 1'b0;
        #1;
        chk("idle_done_a", done_a, 0);
        chk("idle_busy_after_a", busy_a, 0);
        chk("idle_rdy_after_a", in_ready_a, 1);
        chk("idle_sv_a", ser_valid_a, 0);
        $display("word %h serialized (hold_at=%0d hold_len=%0d) total=%0d bad=%0d",
                 w, hold_at, hold_len, total, bad);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        hold     = 1'b0;
        step();
        step();
        chk("rst_busy_a", busy_a, 0);
        chk("rst_sv_a", ser_valid_a, 0);
        chk("rst_ser_a", ser_out_a, 0);
        chk("rst_ser_b", ser_out_b, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_last_a", last_a, 0);
        chk("rst_rdy_a", in_ready_a, 0);
        chk("rst_L_a", l_a, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_rdy_a", in_ready_a, 1);
        chk("post_rst_L_a", l_a, 0);
        step();
        chk("idle_hold_busy_a", busy_a, 0);

        run_word(8'hA5, -1, 0, 1'b0, 1'b0, 8'h00);
        run_word(8'h01, -1, 0, 1'b0, 1'b0, 8'h00);
        run_word(8'hFF, 2, 3, 1'b1, 1'b0, 8'h00);
        run_word(8'hC3, -1, 0, 1'b0, 1'b1, 8'h00);
        in_valid = 1'b0;
        step();
        run_word(8'h81, -1, 0, 1'b0, 1'b1, 8'h7E);
        run_word(8'h7E, -1, 0, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a word, while bit 4 is on the wire.
        in_valid = 1'b1;
        in_data  = 8'h96;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("mid_bit_msb", ser_out_a, 8'h96 >> (7 - k) & 8'h01);
            chk("mid_bit_lsb", ser_out_b, 8'h96 >> k & 8'h01);
            if (k < 4) step();
        end
        reset = 1'b1;
        in_valid = 1'b1;
        step();
        chk("mid_rst_busy_a", busy_a, 0);
        chk("mid_rst_sv_a", ser_valid_a, 0);
        chk("mid_rst_ser_a", ser_out_a, 0);
        chk("mid_rst_done_a", done_a, 0);
        chk("mid_rst_rdy_a", in_ready_a, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_rdy_after_a", in_ready_a, 1);
        chk("mid_rst_busy_b", busy_b, 0);
        $display("word 96 aborted by reset total=%0d bad=%0d", total, bad);
        run_word(8'h3C, -1, 0, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
